memtest_sweep_ctrl: RTL

// Sequences the SDRAM tester across {sz,chip} configurations. Per enabled config: holds tester in reset,

---
 rtl/memtest_sweep_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/memtest_sweep_ctrl.sv
// rtl/memtest_sweep_ctrl.sv - sweeps the SDRAM tester across {sz,chip} configurations
// Ports: clk, rst_n (synchronous, active-low); start/stop pulses, loop and cfg_mask select the sweep;
//        t_passcount/t_failcount report tester progress; t_rst_n/t_sz/t_chip drive the tester;
//        busy/done/cur_idx/result_fail/result_done/wdog_err/sweep_count report sweep status.
// Optional build macro: MEMTEST_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first failed config.
module memtest_sweep_ctrl #(
   parameter logic [31:0] PASSES_PER_CFG = 32'd4,
   parameter int          RST_HOLD       = 16,
   parameter int          WDOG_CYCLES    = 200_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stop,
   input  logic        loop,
   input  logic [15:0] cfg_mask,
   input  logic [31:0] t_passcount,
   input  logic [31:0] t_failcount,
   output logic        t_rst_n,
   output logic [1:0]  t_sz,
   output logic [1:0]  t_chip,
   output logic        busy,
   output logic        done,
   output logic [3:0]  cur_idx,
   output logic [15:0] result_fail,
   output logic [15:0] result_done,
   output logic        wdog_err,
   output logic [15:0] sweep_count
);

   typedef enum logic [2:0] {S_IDLE, S_SCAN, S_HOLD, S_RUN, S_NEXT} state_t;

   state_t      state, state_nx;
   logic [3:0]  idx_nx;
   logic        busy_nx, done_nx, werr_nx;
   logic [15:0] rfail_nx, rdone_nx, count_nx, count_inc;
   logic [31:0] hold_cnt, hold_cnt_nx;
   logic [31:0] wdog, wdog_nx;
   logic [31:0] pass_prev;
   logic        sweep_end, cfg_pass, cfg_fail;

   // The tester config follows cur_idx; cur_idx only moves in SCAN/NEXT/IDLE where t_rst_n is low.
   assign t_sz   = cur_idx[3:2];
   assign t_chip = cur_idx[1:0];

   assign count_inc = (sweep_count == 16'hFFFF) ? sweep_count : sweep_count + 16'd1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      idx_nx      = cur_idx;
      busy_nx     = busy;
      done_nx     = 1'b0;
      werr_nx     = wdog_err;
      rfail_nx    = result_fail;
      rdone_nx    = result_done;
      count_nx    = sweep_count;
      hold_cnt_nx = hold_cnt;
      wdog_nx     = wdog;
      sweep_end   = 1'b0;
      cfg_pass    = 1'b0;
      cfg_fail    = 1'b0;

      if (stop) begin
         // Abort from anywhere; also suppresses a start arriving in the same IDLE cycle.
         state_nx = S_IDLE;
         busy_nx  = 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  rfail_nx = '0;
                  rdone_nx = '0;
                  werr_nx  = 1'b0;
                  idx_nx   = 4'd0;
                  busy_nx  = 1'b1;
                  state_nx = S_SCAN;
               end
            end
            S_SCAN: begin
               // Mask is read live, one index per cycle.
               if (cfg_mask[cur_idx]) begin
                  hold_cnt_nx = '0;
                  state_nx    = S_HOLD;
               end else if (cur_idx != 4'hF) begin
                  idx_nx = cur_idx + 4'd1;
               end else begin
                  sweep_end = 1'b1;
               end
            end
            S_HOLD: begin
               if (hold_cnt == 32'(RST_HOLD - 1)) begin
                  wdog_nx  = '0;
                  state_nx = S_RUN;
               end else begin
                  hold_cnt_nx = hold_cnt + 32'd1;
               end
            end
            S_RUN: begin
               // Any passcount movement counts as progress and restarts the watchdog.
               wdog_nx = (t_passcount != pass_prev) ? 32'd0 : wdog + 32'd1;
               if (t_failcount != 32'd0) begin
                  cfg_fail = 1'b1;
               end else if (t_passcount >= PASSES_PER_CFG) begin
                  cfg_pass = 1'b1;
               end else if (wdog == 32'(WDOG_CYCLES - 1)) begin
                  cfg_fail = 1'b1;
                  werr_nx  = 1'b1;
               end
               if (cfg_fail || cfg_pass) begin
                  rdone_nx[cur_idx] = 1'b1;
                  rfail_nx[cur_idx] = cfg_fail;
                  state_nx          = S_NEXT;
`ifdef MEMTEST_SWEEP_STOP_ON_FAIL_EN
                  if (cfg_fail) begin
                     // Park on the failing config with the tester held in reset; loop is ignored.
                     done_nx  = 1'b1;
                     busy_nx  = 1'b0;
                     count_nx = count_inc;
                     state_nx = S_IDLE;
                  end
`endif
               end
            end
            S_NEXT: begin
               if (cur_idx != 4'hF) begin
                  idx_nx   = cur_idx + 4'd1;
                  state_nx = S_SCAN;
               end else begin
                  sweep_end = 1'b1;
               end
            end
            default: state_nx = S_IDLE;
         endcase

         if (sweep_end) begin
            count_nx = count_inc;
            done_nx  = 1'b1;
            if (loop) begin
               idx_nx   = 4'd0;
               rfail_nx = '0;
               rdone_nx = '0;
               state_nx = S_SCAN;
            end else begin
               busy_nx  = 1'b0;
               state_nx = S_IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         t_rst_n     <= 1'b0;
         cur_idx     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         result_fail <= '0;
         result_done <= '0;
         wdog_err    <= 1'b0;
         sweep_count <= '0;
         hold_cnt    <= '0;
         wdog        <= '0;
         pass_prev   <= '0;
      end else begin
         // Registered decode: the tester is released exactly while the FSM sits in RUN.
         t_rst_n     <= (state_nx == S_RUN);
         cur_idx     <= idx_nx;
         busy        <= busy_nx;
         done        <= done_nx;
         result_fail <= rfail_nx;
         result_done <= rdone_nx;
         wdog_err    <= werr_nx;
         sweep_count <= count_nx;
         hold_cnt    <= hold_cnt_nx;
         wdog        <= wdog_nx;
         pass_prev   <= t_passcount;
      end
   end

endmodule
